// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction-fetch stage of the MIPS core.
// Owns the program counter. Fetches one instruction at a time over a
// req/ack handshake, holds it for the control unit, and computes the
// next PC from the branch and jump selects at retire.
// Optional feature macro: FETCH_RETIRE_CNT_EN (retired-instruction counter).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        sel_pc,
    input  logic        sel_jump,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    // The two low address bits are dropped so the PC is always word-aligned.
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        retire;

    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc;
    assign opcode     = instr[31:26];
    assign funct      = instr[5:0];
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign retire     = (state == EXEC) && !stall;

    // Next-PC selection: jump beats branch, otherwise fall through.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        next_pc = pc_plus4;
        if (sel_jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (sel_pc) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    // Fetch FSM; imem_req and instr_valid are registered alongside the state
    // so they behave as glitch-free state decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= PC_INIT;
            instr       <= 32'h0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= BOOT;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_RETIRE_CNT_EN
    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count <= 32'h0;
        end else if (retire) begin
            retired_count <= retired_count + 32'd1;
        end
    end
`else
    // Counter compiled out: no flops, output tied low.
    assign retired_count = 32'h0;
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a fetch-address scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        sel_pc;
    logic        sel_jump;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired_count;

    // Second instance, booting high in memory for the jump-priority case.
    logic        j_rst_n;
    logic        j_imem_req;
    logic [31:0] j_imem_addr;
    logic        j_imem_ack;
    logic [31:0] j_imem_rdata;
    logic        j_stall;
    logic        j_sel_pc;
    logic        j_sel_jump;
    logic [31:0] j_instr;
    logic [5:0]  j_opcode;
    logic [5:0]  j_funct;
    logic        j_instr_valid;
    logic [31:0] j_pc;
    logic [31:0] j_pc_plus4;
    logic [31:0] j_retired_count;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] rc_model;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0043)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .sel_pc(sel_pc), .sel_jump(sel_jump),
        .instr(instr), .opcode(opcode), .funct(funct),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .retired_count(retired_count)
    );

    instr_fetch_unit #(.RESET_PC(32'h4000_0000)) u_dut_j (
        .clk(clk), .rst_n(j_rst_n),
        .imem_req(j_imem_req), .imem_addr(j_imem_addr),
        .imem_ack(j_imem_ack), .imem_rdata(j_imem_rdata),
        .stall(j_stall), .sel_pc(j_sel_pc), .sel_jump(j_sel_jump),
        .instr(j_instr), .opcode(j_opcode), .funct(j_funct),
        .instr_valid(j_instr_valid), .pc(j_pc), .pc_plus4(j_pc_plus4),
        .retired_count(j_retired_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_next_pc(input logic [31:0] cur_pc, input logic [31:0] ins,
                                                  input logic spc, input logic sj);
        logic [31:0] p4;
        p4 = cur_pc + 32'd4;
        if (sj)       return {p4[31:28], ins[25:0], 2'b00};
        else if (spc) return p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
        else          return p4;
    endfunction

    function automatic logic [31:0] exp_rc();
`ifdef FETCH_RETIRE_CNT_EN
        return rc_model;
`else
        return 32'h0;
`endif
    endfunction

    // Serve one fetch: wait for the request, hold ack off for 'waits' cycles,
    // return 'rdata', stall for 'stalls' cycles, then retire with the given selects.
    task automatic serve(input logic [31:0] rdata, input int waits, input int stalls,
                         input logic spc, input logic sj);
        logic [31:0] exp_addr;
        logic [31:0] nxt;
        for (int i = 0; i < 16 && !imem_req; i++) @(negedge clk);
        check("req_rise", {31'b0, imem_req}, 32'd1);
        check("valid_in_fetch", {31'b0, instr_valid}, 32'd0);
        exp_addr = exp_addr_q.pop_front();
        check("fetch_addr", imem_addr, exp_addr);
        // Selects are junk outside the retire edge and must be ignored.
        sel_pc   = 1'b1;
        sel_jump = 1'b1;
        for (int w = 0; w < waits; w++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            check("wait_req", {31'b0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, exp_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hA5A5_A5A5;
        check("exec_valid", {31'b0, instr_valid}, 32'd1);
        check("exec_req", {31'b0, imem_req}, 32'd0);
        check("exec_instr", instr, rdata);
        check("exec_opcode", {26'b0, opcode}, {26'b0, rdata[31:26]});
        check("exec_funct", {26'b0, funct}, {26'b0, rdata[5:0]});
        check("exec_pc", pc, exp_addr);
        check("exec_pc_plus4", pc_plus4, exp_addr + 32'd4);
        for (int s = 0; s < stalls; s++) begin
            stall = 1'b1;
            @(negedge clk);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_req", {31'b0, imem_req}, 32'd0);
            check("stall_pc", pc, exp_addr);
            check("stall_instr", instr, rdata);
        end
        stall    = 1'b0;
        sel_pc   = spc;
        sel_jump = sj;
        nxt = model_next_pc(exp_addr, rdata, spc, sj);
        exp_addr_q.push_back(nxt);
        rc_model = rc_model + 32'd1;
        @(negedge clk);
        sel_pc   = 1'b0;
        sel_jump = 1'b0;
        check("retire_cnt", retired_count, exp_rc());
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; sel_pc = 1'b0; sel_jump = 1'b0;
        j_rst_n = 1'b0; j_imem_ack = 1'b0; j_imem_rdata = 32'h0;
        j_stall = 1'b0; j_sel_pc = 1'b0; j_sel_jump = 1'b0;
        rc_model = 32'h0;

        // Reset and boot: RESET_PC 0x43 aligns down to 0x40.
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h40);
        check("rst_pc_plus4", pc_plus4, 32'h44);
        check("rst_instr", instr, 32'h0);
        check("rst_cnt", retired_count, 32'h0);
        rst_n = 1'b1;
        check("boot_req_c1", {31'b0, imem_req}, 32'd0);
        check("boot_valid_c1", {31'b0, instr_valid}, 32'd0);
        exp_addr_q.push_back(32'h40);
        @(negedge clk);
        check("boot_req_c2", {31'b0, imem_req}, 32'd1);
        check("boot_addr_c2", imem_addr, 32'h40);

        // Sequential fetch: zero-wait then three-wait.
        serve(32'h2000_0001, 0, 0, 1'b0, 1'b0);
        serve(32'h0000_0020, 3, 0, 1'b0, 1'b0);
        check("seq_cnt2", retired_count, exp_rc());

        // Reset while the fetch at 0x48 is outstanding, with a late ack.
        check("pre_rst_req", {31'b0, imem_req}, 32'd1);
        check("pre_rst_addr", imem_addr, 32'h48);
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("midrst_req", {31'b0, imem_req}, 32'd0);
        check("midrst_pc", pc, 32'h40);
        check("midrst_cnt", retired_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr_q.delete();
        exp_addr_q.push_back(32'h40);
        rc_model = 32'h0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_ack_req", {31'b0, imem_req}, 32'd1);
        check("late_ack_instr", instr, 32'h0);

        // Branch back onto itself, then fall through.
        serve(32'h1000_FFFF, 0, 0, 1'b1, 1'b0);
        serve(32'h1000_FFFF, 0, 0, 1'b0, 1'b0);
        // Stall for 5 EXEC cycles at 0x44.
        serve(32'h0000_0020, 1, 5, 1'b0, 1'b0);
        // Branch from 0x48 down to 0xFFFF_FFFC, then wrap to 0.
        serve(32'h1000_FFEC, 0, 0, 1'b1, 1'b0);
        serve(32'h0000_0020, 2, 0, 1'b0, 1'b0);
        // Jump from 0 to 0x40.
        serve(32'h0800_0010, 0, 1, 1'b0, 1'b1);
        for (int i = 0; i < 16 && !imem_req; i++) @(negedge clk);
        check("final_addr", imem_addr, exp_addr_q.pop_front());

        // Jump priority over branch at 0x4000_0000.
        j_rst_n = 1'b1;
        for (int i = 0; i < 16 && !j_imem_req; i++) @(negedge clk);
        check("j_req", {31'b0, j_imem_req}, 32'd1);
        check("j_addr", j_imem_addr, 32'h4000_0000);
        j_imem_ack   = 1'b1;
        j_imem_rdata = 32'h0800_0010;
        @(negedge clk);
        j_imem_ack = 1'b0;
        check("j_valid", {31'b0, j_instr_valid}, 32'd1);
        j_sel_pc   = 1'b1;
        j_sel_jump = 1'b1;
        @(negedge clk);
        j_sel_pc   = 1'b0;
        j_sel_jump = 1'b0;
        check("j_next_req", {31'b0, j_imem_req}, 32'd1);
        check("j_next_addr", j_imem_addr, 32'h4000_0040);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
